// File: rtl/load_pkg.sv
`default_nettype none
// ============================================================================
// Module   : load_pkg
// Brief    : Shared types and helpers for the load alignment path.
// Revision : 1.0  initial release
// ============================================================================
package load_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE0 = 3'd1,
        WAIT0  = 3'd2,
        ISSUE1 = 3'd3,
        WAIT1  = 3'd4,
        RESP   = 3'd5
    } state_t;

    function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
        return 4'd1 << funct3[1:0];
    endfunction

    // LD and LWU only exist on RV64.
    function automatic logic is_illegal(input logic [2:0] funct3, input int xlen);
        return (funct3 == 3'b111) ||
               ((xlen == 32) && ((funct3 == F3_LD) || (funct3 == F3_LWU)));
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_data_extract.sv
`default_nettype none
// ============================================================================
// Module   : load_data_extract
// Brief    : Combinational merge, byte shift and sign/zero extension of a load.
// Revision : 1.0  initial release
// ============================================================================
module load_data_extract #(
    parameter int XLEN = 32,
    parameter int NB   = XLEN / 8,
    parameter int OFFW = $clog2(NB)
) (
    input  logic [XLEN-1:0] beat0,
    input  logic [XLEN-1:0] beat1,
    input  logic [OFFW-1:0] off,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data
);

    logic [OFFW+2:0] w_shamt;
    logic [XLEN-1:0] w_shifted;
    logic [XLEN-1:0] w_mask;
    logic            w_sign;

    assign w_shamt   = {off, 3'b000};
    assign w_shifted = XLEN'({beat1, beat0} >> w_shamt);

    always_comb begin
        w_sign = 1'b0;
        w_mask = '0;
        case (funct3[1:0])
            2'd0: begin
                w_sign = w_shifted[7];
                w_mask = XLEN'(8'hFF);
            end
            2'd1: begin
                w_sign = w_shifted[15];
                w_mask = XLEN'(16'hFFFF);
            end
            2'd2: begin
                w_sign = w_shifted[31];
                w_mask = XLEN'(32'hFFFF_FFFF);
            end
            default: begin
                w_sign = w_shifted[XLEN-1];
                w_mask = '1;
            end
        endcase
    end

    // funct3[2] selects the unsigned variants.
    assign data = (w_shifted & w_mask) | (~w_mask & {XLEN{w_sign & ~funct3[2]}});

endmodule
`default_nettype wire

// File: rtl/load_align_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_align_unit
// Brief    : Load FSM issuing one or two aligned bus beats per (misaligned) load.
// Revision : 1.0  initial release
// ============================================================================
module load_align_unit
    import load_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NB   = XLEN / 8,
    parameter int OFFW = $clog2(NB)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_addr,
    input  logic [2:0]      req_funct3,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_data,
    output logic            rsp_err
);

    state_t          r_state;
    state_t          w_next;
    logic [XLEN-1:0] r_mem_addr;
    logic [XLEN-1:0] r_beat0;
    logic [XLEN-1:0] r_rsp_data;
    logic            r_rsp_err;
    logic [OFFW-1:0] r_off;
    logic [2:0]      r_funct3;
    logic            r_two_beat;

    logic            w_accept;
    logic            w_illegal;
    logic [4:0]      w_end;
    logic            w_two_beat;
    logic [XLEN-1:0] w_beat0;
    logic [XLEN-1:0] w_extract;

    assign w_accept   = req_valid && req_ready;
    assign w_illegal  = is_illegal(req_funct3, XLEN);
    assign w_end      = 5'(req_addr[OFFW-1:0]) + 5'(size_bytes(req_funct3));
    assign w_two_beat = w_end > 5'(NB);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (req_valid)     w_next = w_illegal ? RESP : ISSUE0;
            ISSUE0:  if (mem_req_ready) w_next = WAIT0;
            WAIT0:   if (mem_rsp_valid) w_next = r_two_beat ? ISSUE1 : RESP;
            ISSUE1:  if (mem_req_ready) w_next = WAIT1;
            WAIT1:   if (mem_rsp_valid) w_next = RESP;
            RESP:    if (rsp_ready)     w_next = IDLE;
            default:                    w_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready     = (r_state == IDLE);
        mem_req_valid = (r_state == ISSUE0) || (r_state == ISSUE1);
        rsp_valid     = (r_state == RESP);
        mem_req_addr  = r_mem_addr;
        rsp_data      = r_rsp_data;
        rsp_err       = r_rsp_err;
    end

    // In WAIT0 the live bus word is beat0; a single-beat load never reads beat1 bytes.
    assign w_beat0 = (r_state == WAIT0) ? mem_rsp_data : r_beat0;

    load_data_extract #(
        .XLEN (XLEN),
        .NB   (NB),
        .OFFW (OFFW)
    ) u_extract (
        .beat0  (w_beat0),
        .beat1  (mem_rsp_data),
        .off    (r_off),
        .funct3 (r_funct3),
        .data   (w_extract)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_addr <= '0;
            r_beat0    <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
            r_off      <= '0;
            r_funct3   <= 3'b000;
            r_two_beat <= 1'b0;
        end else if (w_accept) begin
            r_off      <= req_addr[OFFW-1:0];
            r_funct3   <= req_funct3;
            r_two_beat <= w_two_beat;
            r_rsp_err  <= w_illegal;
            if (w_illegal) begin
                r_rsp_data <= '0;
            end else begin
                r_mem_addr <= {req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
            end
        end else if ((r_state == WAIT0) && mem_rsp_valid) begin
            r_beat0 <= mem_rsp_data;
            if (r_two_beat) begin
                r_mem_addr <= r_mem_addr + XLEN'(NB);
            end else begin
                r_rsp_data <= w_extract;
            end
        end else if ((r_state == WAIT1) && mem_rsp_valid) begin
            r_rsp_data <= w_extract;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_align_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_align_unit
// Brief    : Directed bench for load_align_unit (RV32 and RV64 instances).
// Revision : 1.0  initial release
// ============================================================================
module tb_load_align_unit;
    import load_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    logic        req_valid = 1'b0, req_ready;
    logic [31:0] req_addr = '0;
    logic [2:0]  req_funct3 = '0;
    logic        mem_req_valid, mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
    logic [31:0] rsp_data;

    logic        req_valid_64 = 1'b0, req_ready_64;
    logic [63:0] req_addr_64 = '0;
    logic [2:0]  req_funct3_64 = '0;
    logic        mem_req_valid_64, mem_req_ready_64 = 1'b0;
    logic [63:0] mem_req_addr_64;
    logic        mem_rsp_valid_64 = 1'b0;
    logic [63:0] mem_rsp_data_64 = '0;
    logic        rsp_valid_64, rsp_ready_64 = 1'b0, rsp_err_64;
    logic [63:0] rsp_data_64;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    load_align_unit #(.XLEN(32)) u_dut32 (
        .clk (clk), .rst (rst),
        .req_valid (req_valid), .req_ready (req_ready),
        .req_addr (req_addr), .req_funct3 (req_funct3),
        .mem_req_valid (mem_req_valid), .mem_req_ready (mem_req_ready),
        .mem_req_addr (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid), .mem_rsp_data (mem_rsp_data),
        .rsp_valid (rsp_valid), .rsp_ready (rsp_ready),
        .rsp_data (rsp_data), .rsp_err (rsp_err)
    );

    load_align_unit #(.XLEN(64)) u_dut64 (
        .clk (clk), .rst (rst),
        .req_valid (req_valid_64), .req_ready (req_ready_64),
        .req_addr (req_addr_64), .req_funct3 (req_funct3_64),
        .mem_req_valid (mem_req_valid_64), .mem_req_ready (mem_req_ready_64),
        .mem_req_addr (mem_req_addr_64),
        .mem_rsp_valid (mem_rsp_valid_64), .mem_rsp_data (mem_rsp_data_64),
        .rsp_valid (rsp_valid_64), .rsp_ready (rsp_ready_64),
        .rsp_data (rsp_data_64), .rsp_err (rsp_err_64)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drives one RV32 load, plays the bus for nbeats, then checks the response.
    task automatic load32(input logic [31:0] addr, input logic [2:0] f3, input int nbeats,
                          input logic [31:0] a0, input logic [31:0] d0,
                          input logic [31:0] a1, input logic [31:0] d1,
                          input int stall, input logic [31:0] exp_data, input logic exp_err,
                          input int exp_lat, input int hold);
        int t0;
        int n;
        logic saw;
        logic [31:0] a;
        @(negedge clk);
        check("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_addr = addr; req_funct3 = f3; t0 = cyc;
        @(negedge clk);
        req_valid = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            a = (b == 0) ? a0 : a1;
            n = 0;
            while (!mem_req_valid && n < 20) begin @(negedge clk); n++; end
            check("mem_req_valid", mem_req_valid, 1);
            check("mem_req_addr", mem_req_addr, a);
            for (int s = 0; s < stall; s++) begin
                mem_req_ready = 1'b0;
                @(negedge clk);
                check("mem_req_stall", {mem_req_valid, mem_req_addr}, {1'b1, a});
            end
            mem_req_ready = 1'b1;
            @(negedge clk);
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = (b == 0) ? d0 : d1;
            @(negedge clk);
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = '0;
        end
        n = 0; saw = 1'b0;
        while (!rsp_valid && n < 20) begin
            if (mem_req_valid) saw = 1'b1;
            @(negedge clk); n++;
        end
        check("rsp_valid", rsp_valid, 1);
        if (nbeats == 0) check("no_mem_req", {saw, mem_req_valid}, 2'b00);
        if (exp_lat > 0) check("latency", cyc - t0, exp_lat);
        check("rsp_data", rsp_data, exp_data);
        check("rsp_err", rsp_err, exp_err);
        for (int h = 0; h < hold; h++) begin
            req_valid = 1'b1; req_addr = 32'h3000; req_funct3 = F3_LW;
            @(negedge clk);
            check("rsp_hold", {rsp_valid, rsp_err, rsp_data}, {1'b1, exp_err, exp_data});
            check("no_accept", req_ready, 0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("back_idle", {req_ready, rsp_valid, mem_req_valid}, 3'b100);
    endtask

    task automatic load64(input logic [63:0] addr, input logic [2:0] f3, input int nbeats,
                          input logic [63:0] d0, input logic [63:0] d1,
                          input logic [63:0] exp_data);
        int n;
        logic [63:0] a;
        a = {addr[63:3], 3'b000};
        @(negedge clk);
        req_valid_64 = 1'b1; req_addr_64 = addr; req_funct3_64 = f3;
        @(negedge clk);
        req_valid_64 = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            n = 0;
            while (!mem_req_valid_64 && n < 20) begin @(negedge clk); n++; end
            check("mem_req_valid_64", mem_req_valid_64, 1);
            check("mem_req_addr_64", mem_req_addr_64, a);
            mem_req_ready_64 = 1'b1;
            @(negedge clk);
            mem_req_ready_64 = 1'b0;
            mem_rsp_valid_64 = 1'b1;
            mem_rsp_data_64  = (b == 0) ? d0 : d1;
            @(negedge clk);
            mem_rsp_valid_64 = 1'b0;
            a = a + 64'd8;
        end
        n = 0;
        while (!rsp_valid_64 && n < 20) begin @(negedge clk); n++; end
        check("rsp_valid_64", rsp_valid_64, 1);
        check("rsp_data_64", rsp_data_64, exp_data);
        check("rsp_err_64", rsp_err_64, 0);
        rsp_ready_64 = 1'b1;
        @(negedge clk);
        rsp_ready_64 = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        check("reset_ctrl", {req_ready, mem_req_valid, rsp_valid, rsp_err}, 4'b1000);
        check("reset_addr", mem_req_addr, 0);
        check("reset_data", rsp_data, 0);
        rst = 1'b0;

        // Stray bus response while idle must be ignored.
        @(negedge clk);
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEAD_BEEF;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        check("idle_stray_rsp", {req_ready, rsp_valid}, 2'b10);

        load32(32'h1003, F3_LB,  1, 32'h1000, 32'h80FF_1234, 32'h0, 32'h0, 0, 32'hFFFF_FF80, 1'b0, 3, 0);
        load32(32'h1003, F3_LBU, 1, 32'h1000, 32'h80FF_1234, 32'h0, 32'h0, 0, 32'h0000_0080, 1'b0, 3, 0);
        load32(32'h1002, F3_LHU, 1, 32'h1000, 32'hBEEF_0000, 32'h0, 32'h0, 0, 32'h0000_BEEF, 1'b0, 3, 4);
        load32(32'h1003, F3_LW,  2, 32'h1000, 32'hAA00_0000, 32'h1004, 32'h00CC_BBDD, 0, 32'hCCBB_DDAA, 1'b0, 5, 0);
        load32(32'h1007, F3_LH,  2, 32'h1004, 32'h7F00_0000, 32'h1008, 32'h0000_0012, 3, 32'h0000_127F, 1'b0, -1, 0);
        load32(32'hFFFF_FFFE, F3_LW, 2, 32'hFFFF_FFFC, 32'h5566_7788, 32'h0000_0000, 32'h1122_3344, 0, 32'h3344_5566, 1'b0, 5, 0);
        load32(32'h1000, 3'b011, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 32'h0, 1'b1, 1, 2);
        load32(32'h1000, 3'b110, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 32'h0, 1'b1, 1, 0);
        load32(32'h1000, 3'b111, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 32'h0, 1'b1, 1, 0);

        load64(64'h1005, F3_LD,  2, 64'h8877_6655_4433_2211, 64'hFFEE_DDCC_BBAA_9900, 64'hCCBB_AA99_0088_7766);
        load64(64'h1004, F3_LWU, 1, 64'h8000_0001_0000_0000, 64'h0, 64'h0000_0000_8000_0001);
        load64(64'h1004, F3_LW,  1, 64'h8000_0001_0000_0000, 64'h0, 64'hFFFF_FFFF_8000_0001);

        // Reset while waiting for the second beat of a misaligned LW.
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h1003; req_funct3 = F3_LW;
        @(negedge clk);
        req_valid = 1'b0; mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'hAA00_0000;
        @(negedge clk);
        mem_rsp_valid = 1'b0; mem_req_ready = 1'b1;
        check("issue1_addr", {mem_req_valid, mem_req_addr}, {1'b1, 32'h1004});
        @(negedge clk);
        mem_req_ready = 1'b0;
        check("in_wait1", {req_ready, mem_req_valid, rsp_valid}, 3'b000);
        rst = 1'b1;
        #1;
        check("rst_ctrl", {req_ready, mem_req_valid, rsp_valid, rsp_err}, 4'b1000);
        check("rst_addr", mem_req_addr, 0);
        check("rst_data", rsp_data, 0);
        @(negedge clk);
        rst = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h00CC_BBDD;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        check("late_rsp_ignored", {req_ready, rsp_valid, rsp_data}, {2'b10, 32'h0});

        load32(32'h2000, F3_LW, 1, 32'h2000, 32'h1234_5678, 32'h0, 32'h0, 0, 32'h1234_5678, 1'b0, 3, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/load_align_unit.md
# load_align_unit

Sequential load-data unit for the load path between the LSU address stage and the register-file write-back. It is parametrised in XLEN, so it supports RV32 and RV64 loads: LB/LH/LW/LBU/LHU, plus LD/LWU when XLEN=64. It issues one or two aligned bus beats per load, so misaligned loads that straddle a bus word are completed in hardware. Data is merged, shifted and sign/zero-extended, and returned over valid/ready handshakes.

## Interface
Parameters:
- XLEN, 32: data and address width. Legal values are 32 or 64.
- NB, XLEN/8: bytes per bus word. Derived; do not override.
- OFFW, $clog2(NB): width of the byte-offset field.

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  load request valid
- req_ready  out  1  unit idle; request accepted when req_valid && req_ready
- req_addr  in  XLEN  byte address
- req_funct3  in  3  RISC-V load funct3
- mem_req_valid  out  1  bus read request
- mem_req_ready  in  1  bus accepts request
- mem_req_addr  out  XLEN  word-aligned address (low OFFW bits zero)
- mem_rsp_valid  in  1  bus read data valid; always accepted in WAIT states
- mem_rsp_data  in  XLEN  bus read data
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  XLEN  extended load result
- rsp_err  out  1  illegal funct3; rsp_data=0

## Operation
- Size from funct3[1:0]: 1/2/4/8 bytes. funct3[2]=1 selects zero-extension; otherwise the result is sign-extended.
- Illegal funct3:
  - 3'b111 at any XLEN.
  - 3'b011 and 3'b110 when XLEN=32.
- An illegal request issues no bus beat and goes straight to RESP with rsp_err=1 and rsp_data=0.
- Request fields are captured on accept. off = addr[OFFW-1:0].
- Beat count:
  - One beat when off+size <= NB.
  - Two beats otherwise: base address first, then base+NB. Wrap past the top of the address space is modulo 2^XLEN.
- Merge: the 2*XLEN value {beat1, beat0} is shifted right by 8*off. The low size bytes are then extended to XLEN.
- States:
  - IDLE → ISSUE0 on accept of a legal request; IDLE → RESP on accept of an illegal request.
  - ISSUE0 → WAIT0 on mem_req handshake.
  - WAIT0 → ISSUE1 on mem_rsp_valid when two beats are needed; otherwise WAIT0 → RESP.
  - ISSUE1 → WAIT1 on mem_req handshake.
  - WAIT1 → RESP on mem_rsp_valid.
  - RESP → IDLE on rsp_ready.
- mem_req_valid is high only in ISSUE0/ISSUE1. mem_req_addr stays stable while mem_req_valid is high and mem_req_ready is low.
- mem_rsp_valid outside WAIT0/WAIT1 is ignored (one outstanding beat max).
- rsp_data and rsp_err are registered and held stable while rsp_valid=1 and rsp_ready=0.

## Timing
- Reset values: state=IDLE, req_ready=1, mem_req_valid=0, mem_req_addr=0, rsp_valid=0, rsp_data=0, rsp_err=0.
- rst asserted mid-operation (any state): outputs take their reset values immediately and the transaction is dropped. A late mem_rsp_valid after reset is ignored.
- Accept at cycle T with zero-wait bus (mem_req_ready=1, mem_rsp_valid the cycle after the handshake):
  - Aligned: mem_req at T+1, rsp_valid at T+3.
  - Two-beat: rsp_valid at T+5.
- Illegal funct3: rsp_valid at T+1.
- req_ready is high only in IDLE, so there are no back-to-back accepts. A new accept is possible in the cycle after the RESP handshake.

## Structure
- load_pkg:
  - funct3 localparams F3_LB … F3_LWU.
  - state_t enum (IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP).
  - function size_bytes(funct3).
  - function is_illegal(funct3, XLEN).
- Sub-module load_data_extract: combinational merge/shift/extend of {beat1, beat0}, off and funct3 to XLEN. Contains no state.
- The FSM, capture registers and beat0 buffer live in load_align_unit.

## Test plan
- XLEN=32, LB at 0x1003, beat 0x1000 returns 0x80FF_1234 → one bus beat; rsp_data=0xFFFF_FF80, rsp_err=0, rsp_valid at T+3.
- LHU at 0x1002, beat returns 0xBEEF_0000 → rsp_data=0x0000_BEEF; rsp_ready held low 4 cycles → data stable, no new accept.
- Misaligned LW at 0x1003: beats 0x1000→0xAA00_0000 and 0x1004→0x00CC_BBDD → addresses in that order, rsp_data=0xCCBB_DDAA at T+5.
- Misaligned LH at 0x1007 with mem_req_ready low 3 cycles per beat: beats 0x1004→0x7F00_0000, 0x1008→0x0000_0012 → mem_req_addr stable while stalled; rsp_data=0x0000_127F.
- XLEN=32, funct3=3'b011 → no mem_req_valid; rsp_valid at T+1, rsp_err=1, rsp_data=0. XLEN=64, LD at 0x..05 → two beats, correct 64-bit merge.
- rst pulsed in WAIT1, then mem_rsp_valid arrives → all outputs 0, response ignored; the next aligned LW at 0x2000 with data 0x1234_5678 → rsp_data=0x1234_5678.
